// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - two-direction traffic phase controller with BCD countdowns
module traffic_phase_ctrl #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50_000_000,
  parameter int T_GA     = 40,
  parameter int T_LA     = 15,
  parameter int T_GB     = 30,
  parameter int T_LB     = 15,
  parameter int T_Y      = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  NIGHT,
  output logic [3:0]            LAMPA,
  output logic [3:0]            LAMPB,
  output logic [4*DIGITS-1:0]   ACOUNT,
  output logic [4*DIGITS-1:0]   BCOUNT
);

  localparam int CW    = 4 * DIGITS;
  localparam int DW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXV  = (10 ** DIGITS) - 1;
  localparam int RED_A = T_GA + T_LA + 2 * T_Y;
  localparam int RED_B = T_GB + T_LB + 2 * T_Y;

  localparam logic [3:0] L_LEFT = 4'b0001;
  localparam logic [3:0] L_GRN  = 4'b0010;
  localparam logic [3:0] L_YEL  = 4'b0100;
  localparam logic [3:0] L_RED  = 4'b1000;

  if (TICK_DIV < 1 ||
      T_GA < 1 || T_GA > MAXV || T_LA < 1 || T_LA > MAXV ||
      T_GB < 1 || T_GB > MAXV || T_LB < 1 || T_LB > MAXV ||
      T_Y  < 1 || T_Y  > MAXV || RED_A > MAXV || RED_B > MAXV) begin : g_range_err
    $error("traffic_phase_ctrl: duration or red sum outside BCD display range");
  end

  function automatic logic [CW-1:0] to_bcd(input int v);
    logic [CW-1:0] r;
    int            t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [CW-1:0] B_GA = to_bcd(T_GA);
  localparam logic [CW-1:0] B_LA = to_bcd(T_LA);
  localparam logic [CW-1:0] B_GB = to_bcd(T_GB);
  localparam logic [CW-1:0] B_LB = to_bcd(T_LB);
  localparam logic [CW-1:0] B_Y  = to_bcd(T_Y);
  localparam logic [CW-1:0] B_RA = to_bcd(RED_A);
  localparam logic [CW-1:0] B_RB = to_bcd(RED_B);

  typedef enum logic [3:0] {
    S_HOLD, S_AG, S_AY1, S_AL, S_AY2, S_BG, S_BY1, S_BL, S_BY2, S_FLASH
  } state_t;

  // Divider restarts whenever the controller switches between hold, run and flash.
  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      S_HOLD:  return 2'd0;
      S_FLASH: return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [CW-1:0] dur_of(input state_t s);
    case (s)
      S_AG:                       return B_GA;
      S_AL:                       return B_LA;
      S_BG:                       return B_GB;
      S_BL:                       return B_LB;
      S_AY1, S_AY2, S_BY1, S_BY2: return B_Y;
      default:                    return '0;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      S_AG:    return S_AY1;
      S_AY1:   return S_AL;
      S_AL:    return S_AY2;
      S_AY2:   return S_BG;
      S_BG:    return S_BY1;
      S_BY1:   return S_BL;
      S_BL:    return S_BY2;
      S_BY2:   return S_AG;
      default: return S_HOLD;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      lampa_q, lampa_d, lampb_q, lampb_d;
  logic [CW-1:0]   acnt_q, acnt_d, bcnt_q, bcnt_d;
  logic            tick, a_side_q, a_side_d;
  logic [CW-1:0]   act_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_HOLD;
      div_q   <= '0;
      lampa_q <= L_RED;
      lampb_q <= L_RED;
      acnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      lampa_q <= lampa_d;
      lampb_q <= lampb_d;
      acnt_q  <= acnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    tick     = (div_q == DW'(TICK_DIV - 1));
    a_side_q = state_q inside {S_AG, S_AY1, S_AL, S_AY2};
    act_cnt  = a_side_q ? acnt_q : bcnt_q;

    state_d = state_q;
    if (!EN) begin
      state_d = S_HOLD;
    end else if (NIGHT) begin
      state_d = S_FLASH;
    end else begin
      case (state_q)
        S_HOLD:  state_d = S_AG;
        S_FLASH: state_d = S_HOLD;
        default: if (tick && act_cnt == CW'(1)) state_d = next_phase(state_q);
      endcase
    end
    a_side_d = state_d inside {S_AG, S_AY1, S_AL, S_AY2};

    if (!EN || (mode_of(state_d) != mode_of(state_q)) || tick) div_d = '0;
    else                                                       div_d = div_q + DW'(1);

    lampa_d = lampa_q;
    lampb_d = lampb_q;
    acnt_d  = acnt_q;
    bcnt_d  = bcnt_q;
    case (state_d)
      S_HOLD: begin
        lampa_d = L_RED;
        lampb_d = L_RED;
        acnt_d  = '0;
        bcnt_d  = '0;
      end
      S_FLASH: begin
        acnt_d = '0;
        bcnt_d = '0;
        if (state_q != S_FLASH) begin
          lampa_d = L_YEL;
          lampb_d = L_YEL;
        end else if (tick) begin
          lampa_d = lampa_q ^ L_YEL;
          lampb_d = lampb_q ^ L_YEL;
        end
      end
      default: begin
        lampa_d = L_RED;
        lampb_d = L_RED;
        case (state_d)
          S_AG:         lampa_d = L_GRN;
          S_AY1, S_AY2: lampa_d = L_YEL;
          S_AL:         lampa_d = L_LEFT;
          S_BG:         lampb_d = L_GRN;
          S_BY1, S_BY2: lampb_d = L_YEL;
          S_BL:         lampb_d = L_LEFT;
          default:      ;
        endcase
        // Red side runs one continuous countdown across the other side's four phases.
        if (state_d == S_AG && state_q != S_AG) begin
          acnt_d = B_GA;
          bcnt_d = B_RA;
        end else if (state_d == S_BG && state_q != S_BG) begin
          bcnt_d = B_GB;
          acnt_d = B_RB;
        end else if (state_d != state_q) begin
          if (a_side_d) begin
            acnt_d = dur_of(state_d);
            bcnt_d = bcd_dec(bcnt_q);
          end else begin
            bcnt_d = dur_of(state_d);
            acnt_d = bcd_dec(acnt_q);
          end
        end else if (tick) begin
          acnt_d = bcd_dec(acnt_q);
          bcnt_d = bcd_dec(bcnt_q);
        end
      end
    endcase
  end

  assign LAMPA  = lampa_q;
  assign LAMPB  = lampb_q;
  assign ACOUNT = acnt_q;
  assign BCOUNT = bcnt_q;

endmodule
